// File: rtl/alu_cmd_ctrl.sv
// Command front-end for the 8-bit combinational alu: registers operands, captures
// result/flags into a response channel, and tracks an accumulator and a completion count.
module alu_cmd_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic             cmd_use_acc,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [3:0]       alu_op,
  input  logic [7:0]       alu_result,
  input  logic             alu_zero,
  input  logic             alu_carry,
  input  logic             alu_overflow,
  input  logic             alu_sign,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_result,
  output logic [3:0]       rsp_flags,
  output logic             rsp_err,
  output logic [7:0]       acc,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  logic [7:0]       r_a;
  logic [7:0]       r_b;
  logic [3:0]       r_op;
  logic [7:0]       r_rsp_result;
  logic [3:0]       r_rsp_flags;
  logic             r_rsp_err;
  logic             r_rsp_valid;
  logic             r_cmd_ready;
  logic [7:0]       r_acc;
  logic [CNT_W-1:0] r_op_count;

  logic [7:0] w_opa;
  logic       w_illegal;

  assign w_opa     = cmd_use_acc ? r_acc : cmd_a;
  // Opcodes 1100..1111 are unused by the alu.
  assign w_illegal = (r_op[3:2] == 2'b11);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= '0;
      r_rsp_result <= '0;
      r_rsp_flags  <= '0;
      r_rsp_err    <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_cmd_ready  <= 1'b1;
      r_acc        <= '0;
      r_op_count   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_a         <= w_opa;
            r_b         <= cmd_b;
            r_op        <= cmd_op;
            r_cmd_ready <= 1'b0;
            r_state     <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_illegal) begin
            r_rsp_result <= '0;
            r_rsp_flags  <= '0;
            r_rsp_err    <= 1'b1;
          end else begin
            r_rsp_result <= alu_result;
            r_rsp_flags  <= {alu_zero, alu_carry, alu_overflow, alu_sign};
            r_rsp_err    <= 1'b0;
            r_acc        <= alu_result;
          end
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_op_count  <= r_op_count + 1'b1;
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign alu_op     = r_op;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_flags  = r_rsp_flags;
  assign rsp_err    = r_rsp_err;
  assign acc        = r_acc;
  assign op_count   = r_op_count;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed bench for alu_cmd_ctrl with a behavioural alu attached to its alu_* ports.
module tb_alu_cmd_ctrl;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [3:0]       cmd_op = '0;
  logic [7:0]       cmd_a = '0;
  logic [7:0]       cmd_b = '0;
  logic             cmd_use_acc = 1'b0;
  logic [7:0]       alu_a;
  logic [7:0]       alu_b;
  logic [3:0]       alu_op;
  logic [7:0]       alu_result;
  logic             alu_zero;
  logic             alu_carry;
  logic             alu_overflow;
  logic             alu_sign;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [7:0]       rsp_result;
  logic [3:0]       rsp_flags;
  logic             rsp_err;
  logic [7:0]       acc;
  logic [CNT_W-1:0] op_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_cmd_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .alu_overflow(alu_overflow), .alu_sign(alu_sign),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err), .acc(acc), .op_count(op_count)
  );

  // Behavioural alu; illegal opcodes drive junk the controller must ignore.
  always_comb begin
    logic [8:0] w_sum;
    w_sum        = '0;
    alu_result   = '0;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    case (alu_op)
      4'b0000: begin w_sum = {1'b0, alu_a} + {1'b0, alu_b}; alu_result = w_sum[7:0]; alu_carry = w_sum[8];
                     alu_overflow = (alu_a[7] == alu_b[7]) && (alu_result[7] != alu_a[7]); end
      4'b0001: begin alu_result = alu_a - alu_b; alu_carry = (alu_a < alu_b);
                     alu_overflow = (alu_a[7] != alu_b[7]) && (alu_result[7] != alu_a[7]); end
      4'b0010: begin w_sum = {1'b0, alu_a} + 9'd1; alu_result = w_sum[7:0]; alu_carry = w_sum[8];
                     alu_overflow = (alu_a == 8'h7F); end
      4'b0011: begin alu_result = alu_a - 8'd1; alu_carry = (alu_a == 8'h00); alu_overflow = (alu_a == 8'h80); end
      4'b0100: alu_result = alu_a & alu_b;
      4'b0101: alu_result = alu_a | alu_b;
      4'b0110: alu_result = alu_a ^ alu_b;
      4'b0111: alu_result = ~alu_a;
      4'b1000: begin alu_result = {alu_a[6:0], 1'b0}; alu_carry = alu_a[7]; end
      4'b1001: begin alu_result = {1'b0, alu_a[7:1]}; alu_carry = alu_a[0]; end
      4'b1010: begin alu_result = {alu_a[6:0], alu_a[7]}; alu_carry = alu_a[7]; end
      4'b1011: begin alu_result = {alu_a[0], alu_a[7:1]}; alu_carry = alu_a[0]; end
      default: begin alu_result = 8'hA5; alu_carry = 1'b1; alu_overflow = 1'b1; end
    endcase
    alu_zero = (alu_op[3:2] == 2'b11) ? 1'b1 : (alu_result == 8'h00);
    alu_sign = (alu_op[3:2] == 2'b11) ? 1'b1 : alu_result[7];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, " rsp_result"}, 32'(rsp_result), 32'd0);
    check({tag, " rsp_flags"}, 32'(rsp_flags), 32'd0);
    check({tag, " rsp_err"}, 32'(rsp_err), 32'd0);
    check({tag, " acc"}, 32'(acc), 32'd0);
    check({tag, " op_count"}, 32'(op_count), 32'd0);
    check({tag, " alu_a"}, 32'(alu_a), 32'd0);
    check({tag, " alu_b"}, 32'(alu_b), 32'd0);
    check({tag, " alu_op"}, 32'(alu_op), 32'd0);
  endtask

  // Issue one command with rsp_ready held 1 and check every stage of it.
  task automatic run_cmd(input string tag, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic ua, input logic [7:0] exp_a,
                         input logic [7:0] exp_res, input logic [3:0] exp_flags,
                         input logic exp_err, input logic [7:0] exp_acc, input int exp_cnt);
    int waited;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua; cmd_valid = 1'b1;
    waited = 0;
    while (!cmd_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check({tag, " ready before accept"}, 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    $display("cmd %s op=%b a=%0h b=%0h use_acc=%0d", tag, op, a, b, ua);
    check({tag, " exec cmd_ready"}, 32'(cmd_ready), 32'd0);
    check({tag, " exec rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, " exec alu_a"}, 32'(alu_a), 32'(exp_a));
    check({tag, " exec alu_b"}, 32'(alu_b), 32'(b));
    check({tag, " exec alu_op"}, 32'(alu_op), 32'(op));
    @(posedge clk); #1;
    check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, " resp cmd_ready"}, 32'(cmd_ready), 32'd0);
    check({tag, " rsp_result"}, 32'(rsp_result), 32'(exp_res));
    check({tag, " rsp_flags"}, 32'(rsp_flags), 32'(exp_flags));
    check({tag, " rsp_err"}, 32'(rsp_err), 32'(exp_err));
    check({tag, " acc"}, 32'(acc), 32'(exp_acc));
    @(posedge clk); #1;
    check({tag, " done rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, " done cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, " op_count"}, 32'(op_count), 32'(exp_cnt));
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    //      tag        op       a      b      ua  alu_a  result flags    err  acc    cnt
    run_cmd("add",     4'b0000, 8'd15, 8'd10, 0, 8'd15, 8'd25,  4'b0000, 0, 8'd25,  1);
    run_cmd("sub",     4'b0001, 8'd15, 8'd20, 0, 8'd15, 8'd251, 4'b0101, 0, 8'd251, 2);
    run_cmd("inc_acc", 4'b0010, 8'd0,  8'd0,  1, 8'd251, 8'd252, 4'b0001, 0, 8'd252, 3);
    run_cmd("inc_ff",  4'b0010, 8'hFF, 8'd0,  0, 8'hFF, 8'h00,  4'b1100, 0, 8'h00,  4);
    run_cmd("add_42",  4'b0000, 8'h40, 8'h02, 0, 8'h40, 8'h42,  4'b0000, 0, 8'h42,  5);
    run_cmd("illegal", 4'b1101, 8'd7,  8'd0,  0, 8'd7,  8'h00,  4'b0000, 1, 8'h42,  6);

    // Backpressure: XOR response held while an OR waits on cmd_valid.
    rsp_ready = 1'b0;
    cmd_op = 4'b0110; cmd_a = 8'hAA; cmd_b = 8'hFF; cmd_use_acc = 1'b0; cmd_valid = 1'b1;
    @(posedge clk); #1;
    $display("cmd xor a=aa b=ff with rsp_ready=0");
    cmd_op = 4'b0101; cmd_a = 8'h0F; cmd_b = 8'hF0;
    @(posedge clk); #1;
    check("bp rsp_valid", 32'(rsp_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp hold rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp hold rsp_result", 32'(rsp_result), 32'h55);
      check("bp hold rsp_flags", 32'(rsp_flags), 32'h0);
      check("bp hold cmd_ready", 32'(cmd_ready), 32'd0);
      check("bp hold alu_op", 32'(alu_op), 32'b0110);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp release rsp_valid", 32'(rsp_valid), 32'd0);
    check("bp release cmd_ready", 32'(cmd_ready), 32'd1);
    check("bp release op_count", 32'(op_count), 32'd7);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    $display("cmd or a=0f b=f0 accepted after backpressure");
    check("bp second accepted", 32'(cmd_ready), 32'd0);
    check("bp second alu_a", 32'(alu_a), 32'h0F);
    @(posedge clk); #1;
    check("bp second rsp_result", 32'(rsp_result), 32'hFF);
    check("bp second rsp_flags", 32'(rsp_flags), 32'b0001);
    check("bp second acc", 32'(acc), 32'hFF);
    @(posedge clk); #1;
    check("bp second op_count", 32'(op_count), 32'd8);

    // Reset in the middle of EXEC aborts the ROL.
    cmd_op = 4'b1010; cmd_a = 8'h99; cmd_b = 8'h00; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    $display("cmd rol a=99 interrupted by reset");
    check("rol in exec", 32'(alu_op), 32'b1010);
    rst_n = 1'b0;
    #1 check_reset_outputs("mid reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("post reset no rsp", 32'(rsp_valid), 32'd0);
    end
    check("post reset op_count", 32'(op_count), 32'd0);
    check("post reset acc", 32'(acc), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
